// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared constants for the in-flight result tracker.
// Holds forward-select encoding and ready-stage codes.
package pipe_hazard_tracker_pkg;

    localparam int DEF_STAGES  = 3;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_SRC_CNT = 2;

    localparam int FWD_RF      = 0;
    localparam int RDY_ALU     = 0;
    localparam int RDY_LOAD    = 1;

    function automatic int fwd_sel_of(input int stage);
        return stage + 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_tracker_if.sv
// Decode-side and stage-side bundle of the hazard tracker.
// The controller is the master, the tracker the slave.
interface pipe_hazard_tracker_if #(
    parameter int STAGES  = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SRC_CNT = 2
);
    localparam int SEL_W = $clog2(STAGES + 1);
    localparam int LAT_W = $clog2(STAGES);

    logic                      id_valid;
    logic                      id_flush;
    logic                      id_we;
    logic [ADDR_W-1:0]         id_dest;
    logic [LAT_W-1:0]          id_rdy_stage;
    logic [SRC_CNT-1:0]        id_src_used;
    logic [SRC_CNT*ADDR_W-1:0] id_src_addr;
    logic [SRC_CNT*DATA_W-1:0] id_rf_data;
    logic [STAGES-1:0]         stg_flush;
    logic [STAGES*DATA_W-1:0]  stg_data;
    logic                      stall;
    logic [SRC_CNT*SEL_W-1:0]  fwd_sel;
    logic [SRC_CNT*DATA_W-1:0] fwd_data;
    logic [STAGES-1:0]         stg_valid;

    modport master (
        output id_valid, id_flush, id_we, id_dest, id_rdy_stage,
        output id_src_used, id_src_addr, id_rf_data,
        output stg_flush, stg_data,
        input  stall, fwd_sel, fwd_data, stg_valid
    );

    modport slave (
        input  id_valid, id_flush, id_we, id_dest, id_rdy_stage,
        input  id_src_used, id_src_addr, id_rf_data,
        input  stg_flush, stg_data,
        output stall, fwd_sel, fwd_data, stg_valid
    );

endinterface

// File: rtl/pipe_hazard_tracker_src.sv
// Resolves one decode source against the in-flight entries.
// Youngest live match wins; a not-ready winner makes the source pending.
module pipe_hazard_tracker_src
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2,
    parameter int LAT_W  = 2
) (
    input  logic                     consider,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic [STAGES-1:0]        live,
    input  logic [STAGES*ADDR_W-1:0] dest,
    input  logic [STAGES*LAT_W-1:0]  rdy,
    input  logic [STAGES*DATA_W-1:0] stg_data,
    output logic                     pending,
    output logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        data
);

    logic              hit;
    logic              hit_rdy;
    logic [SEL_W-1:0]  hit_sel;
    logic [DATA_W-1:0] hit_data;

    // Scan oldest to youngest so the lowest index overrides.
    always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_sel  = SEL_W'(FWD_RF);
        hit_data = rf_data;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (live[i] && dest[i*ADDR_W +: ADDR_W] == addr) begin
                hit      = 1'b1;
                hit_rdy  = i >= int'(rdy[i*LAT_W +: LAT_W]);
                hit_sel  = SEL_W'(fwd_sel_of(i));
                hit_data = stg_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        pending = 1'b0;
        sel     = SEL_W'(FWD_RF);
        data    = rf_data;
        if (consider && hit) begin
            if (hit_rdy) begin
                sel  = hit_sel;
                data = hit_data;
            end else begin
                pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// In-flight result tracker between ID and EX: entry shift chain,
// per-source forwarding and the decode stall.
module pipe_hazard_tracker
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int STAGES  = DEF_STAGES,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int SRC_CNT = DEF_SRC_CNT
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_hazard_tracker_if.slave   bus
);

    localparam int SEL_W = $clog2(STAGES + 1);
    localparam int LAT_W = $clog2(STAGES);

    logic [STAGES-1:0]        valid_q, valid_d;
    logic [STAGES-1:0]        we_q, we_d;
    logic [STAGES*ADDR_W-1:0] dest_q, dest_d;
    logic [STAGES*LAT_W-1:0]  rdy_q, rdy_d;

    logic [STAGES-1:0]        live;
    logic [SRC_CNT-1:0]       consider;
    logic [SRC_CNT-1:0]       pending;
    logic                     issue;

    assign issue = bus.id_valid & ~bus.id_flush & ~bus.stall;

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            live[i] = valid_q[i] & we_q[i]
                    & (dest_q[i*ADDR_W +: ADDR_W] != '0)
                    & ~bus.stg_flush[i];
        end
    end

    always_comb begin
        for (int s = 0; s < SRC_CNT; s++) begin
            consider[s] = bus.id_valid & ~bus.id_flush
                        & bus.id_src_used[s]
                        & (bus.id_src_addr[s*ADDR_W +: ADDR_W] != '0);
        end
    end

    for (genvar s = 0; s < SRC_CNT; s++) begin : g_src
        pipe_hazard_tracker_src #(
            .STAGES (STAGES),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .SEL_W  (SEL_W),
            .LAT_W  (LAT_W)
        ) u_src (
            .consider (consider[s]),
            .addr     (bus.id_src_addr[s*ADDR_W +: ADDR_W]),
            .rf_data  (bus.id_rf_data[s*DATA_W +: DATA_W]),
            .live     (live),
            .dest     (dest_q),
            .rdy      (rdy_q),
            .stg_data (bus.stg_data),
            .pending  (pending[s]),
            .sel      (bus.fwd_sel[s*SEL_W +: SEL_W]),
            .data     (bus.fwd_data[s*DATA_W +: DATA_W])
        );
    end

    assign bus.stall     = |pending;
    assign bus.stg_valid = valid_q;

    // A stalled decode slot enters stage 0 as a bubble.
    always_comb begin
        valid_d = '0;
        we_d    = '0;
        dest_d  = '0;
        rdy_d   = '0;
        valid_d[0]          = issue;
        we_d[0]             = bus.id_we;
        dest_d[0 +: ADDR_W] = bus.id_dest;
        rdy_d[0 +: LAT_W]   = bus.id_rdy_stage;
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1] & ~bus.stg_flush[i-1];
            we_d[i]    = we_q[i-1];
            dest_d[i*ADDR_W +: ADDR_W] = dest_q[(i-1)*ADDR_W +: ADDR_W];
            rdy_d[i*LAT_W +: LAT_W]    = rdy_q[(i-1)*LAT_W +: LAT_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            we_q    <= '0;
            dest_q  <= '0;
            rdy_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            dest_q  <= dest_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule
